nbody_step_sequencer: RTL and testbench
=======================================

// Module: nbody_step_sequencer
// PURPOSE
//  Sequences one or more leapfrog steps of the n-body datapath: AddSub pair, x/y/m/vx/vy RAMs, getAccl.
//  Phase ACCEL streams all N*N (i,j) pairs into getAccl and schedules velocity read/accumulate/write-back.
//  Phase POS streams x+=vx, y+=vy for every body.
//  Sits between the bus-facing register block (start/ack/config) and the RAM address/wren muxes.
// PARAMETERS
//  BODIES          512                        max bodies; RAM depth
//  BODY_ADDR_WIDTH $clog2(BODIES)             body index width
//  ACCL_LAT        123                        cycles from pair address issue to ax/ay valid (includes RAM read)
//  ADD_LAT         20                         AddSub latency
//  RAM_LAT         1                          RAM read latency
//  MIN_BODIES      ADD_LAT+RAM_LAT+1          smallest legal N; guarantees v[i] write lands before its next read
// PORTS
//  clk         in  1      clock
//  rst         in  1      synchronous active-high reset
//  start       in  1      pulse; begin run (sampled only in IDLE)
//  ack         in  1      software has read results; clears done
//  abort       in  1      cancel run; return to IDLE
//  num_bodies  in  BAW+1  N, latched at start
//  n_steps     in  32     leapfrog steps per run, latched at start; 0 treated as 1
//  busy        out 1      high in any state except IDLE/DONE
//  done        out 1      level; run complete
//  cfg_err     out 1      level; last start rejected (N<MIN_BODIES or N>BODIES)
//  pair_valid  out 1      p_i_addr/p_j_addr valid this cycle
//  p_i_addr    out BAW    target body i (x/y port A)
//  p_j_addr    out BAW    source body j (x/y port B, m)
//  v_rd_addr   out BAW    vx/vy read address
//  half_kick   out 1      aligned with ax/ay valid; datapath halves accel (first step only)
//  v_wren      out 1      vx/vy write enable
//  v_wr_addr   out BAW    vx/vy write address
//  pos_rd_addr out BAW    x/y port B and v read address in POS
//  pos_wren    out 1      x/y port A write enable
//  pos_wr_addr out BAW    x/y port A write address
//  phase       out 2      0 IDLE/DONE, 1 ACCEL+drain, 2 POS+drain (drives RAM muxes)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; counters, step count and delay lines cleared.
//  States: IDLE -> ACCEL -> ACCEL_DRAIN -> POS -> POS_DRAIN -> (ACCEL | DONE) -> IDLE.
//  IDLE:
//   - start && MIN_BODIES<=N<=BODIES: latch N and n_steps; clear cfg_err; step=0; go to ACCEL.
//   - start with illegal N: cfg_err<=1; stay IDLE.
//  ACCEL: one pair per cycle, j outer 0..N-1, i inner 0..N-1; N*N cycles, no bubbles.
//  Pair issued at cycle t:
//   - v_rd_addr=i at t+ACCL_LAT-RAM_LAT.
//   - half_kick at t+ACCL_LAT iff step==0.
//   - v_wren=1, v_wr_addr=i at t+ACCL_LAT+ADD_LAT.
//   - Scheduling uses shift-register delay lines carrying {valid,i}.
//  ACCEL_DRAIN: entered after the last pair; leave the cycle after the last v_wren. No new pairs issued.
//  POS: k=0..N-1, one per cycle. pos_rd_addr=k and v_rd_addr=k at issue; pos_wren=1, pos_wr_addr=k at issue+RAM_LAT+ADD_LAT.
//  POS_DRAIN: after the last pos_wren, step<=step+1.
//   - step+1==n_steps: go to DONE.
//   - otherwise: go to ACCEL.
//  DONE: done=1, busy=0, held until ack. ack -> done<=0, go to IDLE. ack outside DONE ignored.
//  start while busy or in DONE: ignored.
//  abort (any state, highest priority after rst):
//   - next cycle IDLE; delay lines flushed.
//   - no further v_wren/pos_wren; done stays 0.
//   - RAM contents are partially updated; software must reload.
//  v_wren and pos_wren are never simultaneously high. Address counters wrap at N, not 2^BAW.
//  Cycles per step = N*N + ACCL_LAT + ADD_LAT + N + RAM_LAT + ADD_LAT + 2 (state-transition cycles).
// TESTING
//  1. N=22, n_steps=1, start -> 484 pair_valid, 484 v_wren, 22 pos_wren. half_kick count 484. done at the formula cycle.
//  2. N=21 start -> cfg_err=1, busy stays 0, no enables. N=22 start afterwards -> cfg_err=0, run proceeds.
//  3. N=24, n_steps=3 -> 3*576 v_wren, 72 pos_wren. half_kick only during step 0. done once. ack -> IDLE next cycle.
//  4. abort 100 cycles into ACCEL -> IDLE next cycle; zero v_wren/pos_wren afterwards; done=0.
//  5. start pulses during ACCEL and DONE -> ignored; counts unchanged vs test 1.
//  6. Golden model N=32 with ref RAM/AddSub models: no v[i] read-before-write hazard; final x/y match C model bit-exactly.

Source files
------------

// File: rtl/nbody_step_sequencer.sv
// Leapfrog step sequencer for the n-body datapath: streams (i,j) pairs into getAccl,
// schedules the velocity kick write-back, then the position drift, for n_steps steps.
//
// state        | meaning
// S_IDLE       | waiting for start; config checked here
// S_ACCEL      | one (i,j) pair per cycle, j outer, i inner
// S_ACCEL_DRAIN| waiting for the last velocity write-back
// S_POS        | one body per cycle, x+=vx, y+=vy issue
// S_POS_DRAIN  | waiting for the last position write; step++
// S_DONE       | run complete, holding done until ack
module nbody_step_sequencer #(
    parameter int BODIES          = 512,
    parameter int BODY_ADDR_WIDTH = $clog2(BODIES),
    parameter int ACCL_LAT        = 123,
    parameter int ADD_LAT         = 20,
    parameter int RAM_LAT         = 1,
    parameter int MIN_BODIES      = ADD_LAT + RAM_LAT + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       ack,
    input  logic                       abort,
    input  logic [BODY_ADDR_WIDTH:0]   num_bodies,
    input  logic [31:0]                n_steps,
    output logic                       busy,
    output logic                       done,
    output logic                       cfg_err,
    output logic                       pair_valid,
    output logic [BODY_ADDR_WIDTH-1:0] p_i_addr,
    output logic [BODY_ADDR_WIDTH-1:0] p_j_addr,
    output logic [BODY_ADDR_WIDTH-1:0] v_rd_addr,
    output logic                       half_kick,
    output logic                       v_wren,
    output logic [BODY_ADDR_WIDTH-1:0] v_wr_addr,
    output logic [BODY_ADDR_WIDTH-1:0] pos_rd_addr,
    output logic                       pos_wren,
    output logic [BODY_ADDR_WIDTH-1:0] pos_wr_addr,
    output logic [1:0]                 phase
);

    localparam int BAW      = BODY_ADDR_WIDTH;
    localparam int ACC_DL   = ACCL_LAT + ADD_LAT;
    localparam int POS_DL   = RAM_LAT + ADD_LAT;
    localparam int VRD_TAP  = ACCL_LAT - RAM_LAT - 1;
    localparam int KICK_TAP = ACCL_LAT - 1;
    localparam int DCW      = $clog2(ACC_DL + 1);

    localparam logic [BAW:0]   MIN_N        = (BAW+1)'(MIN_BODIES);
    localparam logic [BAW:0]   MAX_N        = (BAW+1)'(BODIES);
    localparam logic [DCW-1:0] ACC_DRAIN_LD = DCW'(ACC_DL);
    localparam logic [DCW-1:0] POS_DRAIN_LD = DCW'(POS_DL);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEL,
        S_ACCEL_DRAIN,
        S_POS,
        S_POS_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [BAW:0]   n_lat;
    logic [31:0]    steps_lat;
    logic [31:0]    step_cnt;
    logic [BAW-1:0] i_cnt, j_cnt, k_cnt;
    logic [DCW-1:0] drain_cnt;

    logic [ACC_DL-1:0] acc_vld;
    logic [BAW-1:0]    acc_addr [ACC_DL];
    logic [POS_DL-1:0] pos_vld;
    logic [BAW-1:0]    pos_addr [POS_DL];

    logic [BAW:0] last_idx;
    logic         n_legal, i_last, j_last, k_last, drain_zero, last_step;

    assign n_legal    = (num_bodies >= MIN_N) && (num_bodies <= MAX_N);
    assign last_idx   = n_lat - 1'b1;
    assign i_last     = ({1'b0, i_cnt} == last_idx);
    assign j_last     = ({1'b0, j_cnt} == last_idx);
    assign k_last     = ({1'b0, k_cnt} == last_idx);
    assign drain_zero = (drain_cnt == '0);
    assign last_step  = ((step_cnt + 32'd1) == steps_lat);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:        if (start && n_legal) state_nxt = S_ACCEL;
            S_ACCEL:       if (i_last && j_last) state_nxt = S_ACCEL_DRAIN;
            S_ACCEL_DRAIN: if (drain_zero) state_nxt = S_POS;
            S_POS:         if (k_last) state_nxt = S_POS_DRAIN;
            S_POS_DRAIN:   if (drain_zero) state_nxt = last_step ? S_DONE : S_ACCEL;
            S_DONE:        if (ack) state_nxt = S_IDLE;
            default:       state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    // Write enables are masked by abort so nothing lands in RAM from the abort cycle on.
    always_comb begin
        busy        = (state != S_IDLE) && (state != S_DONE);
        done        = (state == S_DONE);
        phase       = 2'd0;
        if ((state == S_ACCEL) || (state == S_ACCEL_DRAIN)) phase = 2'd1;
        if ((state == S_POS) || (state == S_POS_DRAIN))     phase = 2'd2;
        pair_valid  = (state == S_ACCEL);
        p_i_addr    = pair_valid ? i_cnt : '0;
        p_j_addr    = pair_valid ? j_cnt : '0;
        half_kick   = acc_vld[KICK_TAP] && (step_cnt == '0);
        v_wren      = acc_vld[ACC_DL-1] && !abort;
        v_wr_addr   = v_wren ? acc_addr[ACC_DL-1] : '0;
        pos_rd_addr = (state == S_POS) ? k_cnt : '0;
        v_rd_addr   = '0;
        if (state == S_POS)          v_rd_addr = k_cnt;
        else if (acc_vld[VRD_TAP])   v_rd_addr = acc_addr[VRD_TAP];
        pos_wren    = pos_vld[POS_DL-1] && !abort;
        pos_wr_addr = pos_wren ? pos_addr[POS_DL-1] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_lat     <= '0;
            steps_lat <= '0;
            step_cnt  <= '0;
            cfg_err   <= 1'b0;
            i_cnt     <= '0;
            j_cnt     <= '0;
            k_cnt     <= '0;
            drain_cnt <= '0;
        end else if (abort) begin
            i_cnt     <= '0;
            j_cnt     <= '0;
            k_cnt     <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (n_legal) begin
                            n_lat     <= num_bodies;
                            steps_lat <= (n_steps == '0) ? 32'd1 : n_steps;
                            step_cnt  <= '0;
                            cfg_err   <= 1'b0;
                            i_cnt     <= '0;
                            j_cnt     <= '0;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                S_ACCEL: begin
                    if (i_last) begin
                        i_cnt <= '0;
                        j_cnt <= j_last ? '0 : j_cnt + 1'b1;
                    end else begin
                        i_cnt <= i_cnt + 1'b1;
                    end
                    if (i_last && j_last) drain_cnt <= ACC_DRAIN_LD;
                end
                S_ACCEL_DRAIN: begin
                    k_cnt <= '0;
                    if (!drain_zero) drain_cnt <= drain_cnt - 1'b1;
                end
                S_POS: begin
                    k_cnt <= k_last ? '0 : k_cnt + 1'b1;
                    if (k_last) drain_cnt <= POS_DRAIN_LD;
                end
                S_POS_DRAIN: begin
                    i_cnt <= '0;
                    j_cnt <= '0;
                    if (!drain_zero) drain_cnt <= drain_cnt - 1'b1;
                    else             step_cnt  <= step_cnt + 32'd1;
                end
                default: ;
            endcase
        end
    end

    // {valid,i} delay lines: entry k holds what was issued k+1 cycles ago.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            acc_vld <= '0;
            pos_vld <= '0;
            for (int k = 0; k < ACC_DL; k++) acc_addr[k] <= '0;
            for (int k = 0; k < POS_DL; k++) pos_addr[k] <= '0;
        end else begin
            acc_vld     <= {acc_vld[ACC_DL-2:0], (state == S_ACCEL)};
            acc_addr[0] <= i_cnt;
            for (int k = 1; k < ACC_DL; k++) acc_addr[k] <= acc_addr[k-1];
            pos_vld     <= {pos_vld[POS_DL-2:0], (state == S_POS)};
            pos_addr[0] <= k_cnt;
            for (int k = 1; k < POS_DL; k++) pos_addr[k] <= pos_addr[k-1];
        end
    end

endmodule

// File: tb/tb_nbody_step_sequencer.sv
// Self-checking bench for nbody_step_sequencer: schedule model derived from the step timing
// rules, plus an integer datapath model that exposes velocity read-before-write hazards.
module tb_nbody_step_sequencer;

    localparam int BODIES   = 512;
    localparam int BAW      = 9;
    localparam int ACCL_LAT = 123;
    localparam int ADD_LAT  = 20;
    localparam int RAM_LAT  = 1;
    localparam int DP       = RAM_LAT + ADD_LAT;
    localparam int PAD      = ACCL_LAT + ADD_LAT + RAM_LAT + ADD_LAT + 2;

    logic           clk = 1'b0;
    logic           rst, start, ack, abort;
    logic [BAW:0]   num_bodies;
    logic [31:0]    n_steps;
    logic           busy, done, cfg_err, pair_valid, half_kick, v_wren, pos_wren;
    logic [BAW-1:0] p_i_addr, p_j_addr, v_rd_addr, v_wr_addr, pos_rd_addr, pos_wr_addr;
    logic [1:0]     phase;

    nbody_step_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .ack(ack), .abort(abort),
        .num_bodies(num_bodies), .n_steps(n_steps),
        .busy(busy), .done(done), .cfg_err(cfg_err),
        .pair_valid(pair_valid), .p_i_addr(p_i_addr), .p_j_addr(p_j_addr),
        .v_rd_addr(v_rd_addr), .half_kick(half_kick),
        .v_wren(v_wren), .v_wr_addr(v_wr_addr),
        .pos_rd_addr(pos_rd_addr), .pos_wren(pos_wren), .pos_wr_addr(pos_wr_addr),
        .phase(phase)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int c; int a; int b; } ev_t;
    ev_t pv_q[$];
    ev_t vw_q[$];
    ev_t pw_q[$];
    int  hk_q[$];
    int  done_rise = -1;
    bit  done_d = 1'b0;
    int  both_wren = 0;

    int vram [BODIES];
    int xram [BODIES];
    int vrd_h [64];
    int xrd_h [64];
    bit kick_h [64];

    // Event capture and datapath model: a velocity update adds 2 per pair (1 when halved),
    // a position update adds the velocity read alongside it.
    always @(negedge clk) begin
        if (pair_valid) pv_q.push_back('{cyc, int'(p_i_addr), int'(p_j_addr)});
        if (v_wren)     vw_q.push_back('{cyc, int'(v_wr_addr), 0});
        if (pos_wren)   pw_q.push_back('{cyc, int'(pos_wr_addr), 0});
        if (half_kick)  hk_q.push_back(cyc);
        if (v_wren && pos_wren) both_wren++;
        if (done && !done_d) done_rise = cyc;
        done_d = done;
        vrd_h[cyc % 64]  = vram[v_rd_addr];
        xrd_h[cyc % 64]  = xram[pos_rd_addr];
        kick_h[cyc % 64] = half_kick;
        if (v_wren)
            vram[v_wr_addr] = vrd_h[(cyc - DP) % 64] + (kick_h[(cyc - DP + RAM_LAT) % 64] ? 1 : 2);
        if (pos_wren)
            xram[pos_wr_addr] = xrd_h[(cyc - DP) % 64] + vrd_h[(cyc - DP) % 64];
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_events();
        pv_q.delete();
        vw_q.delete();
        pw_q.delete();
        hk_q.delete();
        done_rise = -1;
    endtask

    task automatic apply_start(input int n, input int s, output int sc);
        @(negedge clk);
        num_bodies = (BAW+1)'(n);
        n_steps    = s;
        start      = 1'b1;
        sc         = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_check(input int n, input int steps_in, input bit inject, input string tag);
        int steps, period, sc, errs, s, p, base;
        steps  = (steps_in == 0) ? 1 : steps_in;
        period = n * n + n + PAD;
        clear_events();
        apply_start(n, steps_in, sc);
        for (int w = 0; w < steps * period + 100 && !done; w++) begin
            @(negedge clk);
            if (inject && cyc == sc + 50) begin
                start      = 1'b1;
                num_bodies = 10'd30;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check({tag, " done_seen"}, done, 1);
        if (inject) begin
            @(negedge clk);
            num_bodies = 10'd22;
            start      = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check({tag, " start_in_done"}, {busy, done, pair_valid}, 3'b010);
        end
        repeat (2) @(negedge clk);
        check({tag, " done_held"}, done, 1);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check({tag, " ack_to_idle"}, {done, busy, phase}, 0);

        check({tag, " pair_count"}, pv_q.size(), steps * n * n);
        errs = 0;
        foreach (pv_q[x]) begin
            s = x / (n * n);
            p = x % (n * n);
            if (pv_q[x].c != sc + 1 + s * period + p || pv_q[x].a != p % n || pv_q[x].b != p / n)
                errs++;
        end
        check({tag, " pair_sched_errs"}, errs, 0);

        check({tag, " vwren_count"}, vw_q.size(), steps * n * n);
        errs = 0;
        foreach (vw_q[x]) begin
            s = x / (n * n);
            p = x % (n * n);
            if (vw_q[x].c != sc + 1 + s * period + p + ACCL_LAT + ADD_LAT || vw_q[x].a != p % n)
                errs++;
        end
        check({tag, " vwren_sched_errs"}, errs, 0);

        check({tag, " kick_count"}, hk_q.size(), n * n);
        errs = 0;
        foreach (hk_q[x]) if (hk_q[x] != sc + 1 + x + ACCL_LAT) errs++;
        check({tag, " kick_sched_errs"}, errs, 0);

        check({tag, " poswren_count"}, pw_q.size(), steps * n);
        errs = 0;
        foreach (pw_q[x]) begin
            s    = x / n;
            p    = x % n;
            base = sc + 1 + s * period + n * n + (ACCL_LAT + ADD_LAT + 1);
            if (pw_q[x].c != base + p + RAM_LAT + ADD_LAT || pw_q[x].a != p) errs++;
        end
        check({tag, " poswren_sched_errs"}, errs, 0);

        check({tag, " done_cycle"}, done_rise, sc + 1 + steps * period);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int sc, ab, cnt, n, errs, v, x;
        int v0 [BODIES];
        int x0 [BODIES];

        rst = 1'b1; start = 1'b0; ack = 1'b0; abort = 1'b0;
        num_bodies = '0; n_steps = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_ctrl", {busy, done, cfg_err, pair_valid, v_wren, pos_wren, half_kick}, 0);
        check("rst_phase", phase, 0);
        check("rst_addr", {p_i_addr, p_j_addr, v_rd_addr, v_wr_addr, pos_rd_addr, pos_wr_addr}, 0);

        // Illegal N below and above the legal window
        clear_events();
        apply_start(21, 1, sc);
        check("cfg_low_err", cfg_err, 1);
        check("cfg_low_busy", busy, 0);
        apply_start(513, 1, sc);
        repeat (5) @(negedge clk);
        check("cfg_high_err", cfg_err, 1);
        check("cfg_no_pairs", pv_q.size() + vw_q.size() + pw_q.size(), 0);

        // ack outside DONE is ignored
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("ack_idle_noop", {busy, done}, 0);

        run_check(22, 1, 1'b1, "n22");
        check("cfg_cleared", cfg_err, 0);

        run_check(24, 3, 1'b0, "n24x3");

        n = $urandom_range(22, 40);
        run_check(n, 0, 1'b0, "rand_steps0");

        // Abort 100 cycles into ACCEL
        clear_events();
        apply_start(30, 1, sc);
        repeat (100) @(negedge clk);
        abort = 1'b1;
        ab    = cyc;
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle", {busy, phase, pair_valid}, 0);
        repeat (300) @(negedge clk);
        check("abort_pairs", pv_q.size(), 101);
        cnt = vw_q.size() + pw_q.size();
        check("abort_no_wren", cnt, 0);
        check("abort_done", {done, busy}, 0);

        // Golden datapath model
        for (int i = 0; i < BODIES; i++) begin
            vram[i] = $urandom_range(0, 1000);
            xram[i] = $urandom_range(0, 100000);
            v0[i]   = vram[i];
            x0[i]   = xram[i];
        end
        run_check(32, 2, 1'b0, "gold");
        errs = 0;
        for (int i = 0; i < 32; i++) begin
            v = v0[i];
            x = x0[i];
            for (int s = 0; s < 2; s++) begin
                v = v + ((s == 0) ? 32 : 64);
                x = x + v;
            end
            if (vram[i] != v || xram[i] != x) errs++;
        end
        check("gold_data_errs", errs, 0);
        check("gold_untouched", vram[40] == v0[40] && xram[40] == x0[40], 1);

        check("wren_exclusive", both_wren, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
